// File: rtl/reg_load_arbiter.sv
// -----------------------------------------------------------------------------
// reg_load_arbiter
//
// Shares the load port of one Register (SIZE-bit data plus a 1-bit side flag)
// among NREQ requesters. Pending requests are arbitrated round-robin. The
// winner's data and flag are staged, driven to the Register with a one-cycle
// ld strobe, and the winner then receives a one-cycle one-hot ack. A new
// arbitration can happen at most once every three cycles.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   req        per-requester load request, held until the matching ack
//   req_data   requester i's data in bits [i*SIZE +: SIZE]
//   req_flag   per-requester side-flag bit
//   ld         load strobe to the Register
//   ld_data    staged data to the Register (holds its value while idle)
//   ld_flag    staged side flag to the Register (holds its value while idle)
//   ack        one-hot, one-cycle completion pulse to the winner
//   grant_idx  index of the current or last granted requester
//   busy       high whenever a grant is in progress
//
// All outputs come straight from flops; req only reaches them through the
// grant edge.
// -----------------------------------------------------------------------------
module reg_load_arbiter #(
   parameter int NREQ = 4,
   parameter int SIZE = 2,
   parameter int IDXW = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*SIZE-1:0] req_data,
   input  logic [NREQ-1:0]      req_flag,
   output logic                 ld,
   output logic [SIZE-1:0]      ld_data,
   output logic                 ld_flag,
   output logic [NREQ-1:0]      ack,
   output logic [IDXW-1:0]      grant_idx,
   output logic                 busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ACK  = 2'd2
   } state_e;

   state_e          state_q;
   logic [IDXW-1:0] ptr_q;       // highest-priority requester for the next grant

   logic            win_any_d;
   logic [IDXW-1:0] win_idx_d;
   logic [SIZE-1:0] win_data_d;
   logic            win_flag_d;
   int              best_off;
   int              off;

   // Round-robin pick: each asserted requester's distance from ptr_q along the
   // scan order ptr, ptr+1, ..., wrapping at NREQ; the smallest distance wins.
   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      win_any_d  = |req;
      win_idx_d  = '0;
      win_data_d = '0;
      win_flag_d = 1'b0;
      best_off   = NREQ;
      off        = 0;
      for (int i = 0; i < NREQ; i++) begin
         off = (i + NREQ - int'(ptr_q)) % NREQ;
         if (req[i] && (off < best_off)) begin
            best_off   = off;
            win_idx_d  = IDXW'(i);
            win_data_d = req_data[i*SIZE +: SIZE];
            win_flag_d = req_flag[i];
         end
      end
   end

   // Single FSM block; every output is a register updated here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         ld        <= 1'b0;
         ld_data   <= '0;
         ld_flag   <= 1'b0;
         ack       <= '0;
         grant_idx <= '0;
         busy      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values from
         // before this edge, independent of statement order.
         unique case (state_q)
            S_IDLE: begin
               if (win_any_d) begin
                  // Data and flag are frozen here; later req_* changes do not
                  // reach the load in progress.
                  grant_idx <= win_idx_d;
                  ld_data   <= win_data_d;
                  ld_flag   <= win_flag_d;
                  ld        <= 1'b1;
                  busy      <= 1'b1;
                  state_q   <= S_LOAD;
               end
            end
            S_LOAD: begin
               // The Register loads at this edge; the ack follows regardless of
               // whether the winner still holds req.
               ld      <= 1'b0;
               ack     <= NREQ'(1) << grant_idx;
               state_q <= S_ACK;
            end
            S_ACK: begin
               ack     <= '0;
               busy    <= 1'b0;
               ptr_q   <= (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               ld      <= 1'b0;
               ack     <= '0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_load_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_load_arbiter
//
// Self-checking bench for reg_load_arbiter. A transaction-level model keeps
// the grant phase (idle / loading / acking), the round-robin pointer and the
// staged grant, and is advanced on every rising edge from the same inputs the
// DUT sees. A small model of the downstream Register captures ld_data/ld_flag
// whenever ld is high. Outputs are compared 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_reg_load_arbiter;

   localparam int NREQ = 4;
   localparam int SIZE = 2;
   localparam int IDXW = 2;
   localparam int VW   = 1 + SIZE + 1 + NREQ + IDXW + 1;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*SIZE-1:0] req_data = '0;
   logic [NREQ-1:0]      req_flag = '0;
   logic                 ld;
   logic [SIZE-1:0]      ld_data;
   logic                 ld_flag;
   logic [NREQ-1:0]      ack;
   logic [IDXW-1:0]      grant_idx;
   logic                 busy;

   reg_load_arbiter #(.NREQ(NREQ), .SIZE(SIZE), .IDXW(IDXW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .req_flag  (req_flag),
      .ld        (ld),
      .ld_data   (ld_data),
      .ld_flag   (ld_flag),
      .ack       (ack),
      .grant_idx (grant_idx),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   wire [VW-1:0] dut_vec = {ld, ld_data, ld_flag, ack, grant_idx, busy};

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   // Transaction-level model: phase 0 idle, 1 load cycle, 2 ack cycle.
   int              m_phase;
   int              m_ptr;
   int              m_gidx;
   logic [SIZE-1:0] m_data;
   logic            m_flag;
   int              m_done;      // requester whose ack ended at the last edge, else -1

   // Downstream Register model.
   logic [SIZE-1:0] reg_data;
   logic            reg_flag;

   task automatic model_reset();
      m_phase = 0;
      m_ptr   = 0;
      m_gidx  = 0;
      m_data  = '0;
      m_flag  = 1'b0;
      m_done  = -1;
   endtask

   task automatic model_edge();
      m_done = -1;
      if (m_phase == 0) begin
         for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (req[idx]) begin
               m_gidx  = idx;
               m_data  = req_data[idx*SIZE +: SIZE];
               m_flag  = req_flag[idx];
               m_phase = 1;
               break;
            end
         end
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else begin
         m_phase = 0;
         m_ptr   = (m_gidx + 1) % NREQ;
         m_done  = m_gidx;
      end
   endtask

   function automatic logic [VW-1:0] model_vec();
      logic [NREQ-1:0] a;
      a = '0;
      if (m_phase == 2) a[m_gidx] = 1'b1;
      return {(m_phase == 1), m_data, m_flag, a, IDXW'(m_gidx), (m_phase != 0)};
   endfunction

   // One clock: sample what the Register sees, take the edge, advance models.
   task automatic step();
      logic            l;
      logic [SIZE-1:0] d;
      logic            f;
      l = ld;
      d = ld_data;
      f = ld_flag;
      @(posedge clk);
      cyc++;
      if (!rst) begin
         model_reset();
         reg_data = '0;
         reg_flag = 1'b0;
      end else begin
         model_edge();
         if (l) begin
            reg_data = d;
            reg_flag = f;
         end
      end
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      model_reset();
      step();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (dut_vec !== '0) begin
            tests_failed++;
            $display("FAIL reset_hold cyc=%0d got %b exp %b", cyc, dut_vec, {VW{1'b0}});
         end
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single();
      req      = 4'b0100;
      req_data = '0;
      req_data[2*SIZE +: SIZE] = 2'b10;
      req_flag = 4'b0100;
      step();   // grant edge
      tests_run++;
      if ({ld, ld_data, ld_flag, grant_idx, busy} !== {1'b1, 2'b10, 1'b1, 2'd2, 1'b1}) begin
         tests_failed++;
         $display("FAIL single_load cyc=%0d got ld/data/flag/idx/busy=%b exp %b", cyc,
                  {ld, ld_data, ld_flag, grant_idx, busy}, {1'b1, 2'b10, 1'b1, 2'd2, 1'b1});
      end
      step();   // Register loads at this edge
      tests_run++;
      if ({ld, ack, busy} !== {1'b0, 4'b0100, 1'b1}) begin
         tests_failed++;
         $display("FAIL single_ack cyc=%0d got ld/ack/busy=%b exp %b", cyc,
                  {ld, ack, busy}, {1'b0, 4'b0100, 1'b1});
      end
      tests_run++;
      if ({reg_data, reg_flag} !== {2'b10, 1'b1}) begin
         tests_failed++;
         $display("FAIL single_register got %b exp %b", {reg_data, reg_flag}, {2'b10, 1'b1});
      end
      step();
      req = '0;
      tests_run++;
      if ({ld, ack, busy, grant_idx} !== {1'b0, 4'b0000, 1'b0, 2'd2}) begin
         tests_failed++;
         $display("FAIL single_done cyc=%0d got ld/ack/busy/idx=%b exp %b", cyc,
                  {ld, ack, busy, grant_idx}, {1'b0, 4'b0000, 1'b0, 2'd2});
      end
      step();
      tests_run++;
      if (dut_vec !== model_vec()) begin
         tests_failed++;
         $display("FAIL single_idle cyc=%0d got %b exp %b", cyc, dut_vec, model_vec());
      end
   endtask

   // Pointer sits at 3 after the single grant; 3 must win before 0.
   task automatic test_wrap();
      int got[$];
      req      = 4'b1001;
      req_data = NREQ*SIZE'($urandom);
      req_flag = NREQ'($urandom);
      for (int i = 0; i < 8; i++) begin
         step();
         tests_run++;
         if (dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL wrap_vec cyc=%0d got %b exp %b", cyc, dut_vec, model_vec());
         end
         if (ld) got.push_back(int'(grant_idx));
         if (m_done >= 0) req[m_done] = 1'b0;
      end
      tests_run++;
      if (got.size() != 2 || got[0] != 3 || got[1] != 0) begin
         tests_failed++;
         $display("FAIL wrap_order got %p exp '{3, 0}", got);
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      int when[$];
      pulse_reset();
      req      = 4'b1111;
      req_data = NREQ*SIZE'($urandom);
      req_flag = NREQ'($urandom);
      for (int i = 0; i < 14; i++) begin
         step();
         tests_run++;
         if (dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL rr_vec cyc=%0d got %b exp %b", cyc, dut_vec, model_vec());
         end
         if (ld) begin
            order.push_back(int'(grant_idx));
            when.push_back(cyc);
         end
         if (m_done >= 0) req[m_done] = 1'b0;
      end
      tests_run++;
      if (order.size() != 4) begin
         tests_failed++;
         $display("FAIL rr_count got %0d exp 4", order.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (order[i] != i) begin
               tests_failed++;
               $display("FAIL rr_order slot %0d got %0d exp %0d", i, order[i], i);
            end
            if (i > 0) begin
               tests_run++;
               if (when[i] - when[i-1] != 3) begin
                  tests_failed++;
                  $display("FAIL rr_spacing slot %0d got %0d exp 3", i, when[i] - when[i-1]);
               end
            end
         end
      end
   endtask

   task automatic test_data_stable();
      req      = 4'b0010;
      req_data = '0;
      req_data[1*SIZE +: SIZE] = 2'b01;
      req_flag = 4'b0010;
      step();   // grant
      tests_run++;
      if ({ld, ld_data, grant_idx} !== {1'b1, 2'b01, 2'd1}) begin
         tests_failed++;
         $display("FAIL stable_grant got ld/data/idx=%b exp %b", {ld, ld_data, grant_idx},
                  {1'b1, 2'b01, 2'd1});
      end
      req_data[1*SIZE +: SIZE] = 2'b11;
      req_flag[1] = 1'b0;
      step();   // Register loads
      tests_run++;
      if ({reg_data, reg_flag, ld_data} !== {2'b01, 1'b1, 2'b01}) begin
         tests_failed++;
         $display("FAIL stable_capture got reg/flag/ld_data=%b exp %b",
                  {reg_data, reg_flag, ld_data}, {2'b01, 1'b1, 2'b01});
      end
      step();
      req = '0;
      step();
      tests_run++;
      if ({ld, ld_data, ld_flag, busy} !== {1'b0, 2'b01, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL stable_hold got ld/data/flag/busy=%b exp %b",
                  {ld, ld_data, ld_flag, busy}, {1'b0, 2'b01, 1'b1, 1'b0});
      end
   endtask

   task automatic test_reset_mid();
      req      = 4'b1000;
      req_data = '0;
      req_data[3*SIZE +: SIZE] = 2'b11;
      req_flag = 4'b1000;
      step();
      tests_run++;
      if ({ld, grant_idx, ld_data} !== {1'b1, 2'd3, 2'b11}) begin
         tests_failed++;
         $display("FAIL midrst_grant got ld/idx/data=%b exp %b", {ld, grant_idx, ld_data},
                  {1'b1, 2'd3, 2'b11});
      end
      #2;
      rst = 1'b0;
      model_reset();
      #1;   // still well before the next rising edge
      tests_run++;
      if ({ld, ack, busy, grant_idx, ld_data} !== '0) begin
         tests_failed++;
         $display("FAIL midrst_async got ld/ack/busy/idx/data=%b exp 0",
                  {ld, ack, busy, grant_idx, ld_data});
      end
      req = '0;
      step();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         tests_run++;
         if (ld !== 1'b0 || dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL midrst_idle cyc=%0d got %b exp %b", cyc, dut_vec, model_vec());
         end
      end
   endtask

   // req[0] stays high past its ack while req[2] waits: 2 must be served first.
   task automatic test_sticky();
      int got[$];
      req      = 4'b0001;
      req_data = NREQ*SIZE'($urandom);
      req_flag = NREQ'($urandom);
      step();
      if (ld) got.push_back(int'(grant_idx));
      req[2] = 1'b1;   // arrives during LOAD, must wait for IDLE
      for (int i = 0; i < 10; i++) begin
         step();
         tests_run++;
         if (dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL sticky_vec cyc=%0d got %b exp %b", cyc, dut_vec, model_vec());
         end
         if (ld) got.push_back(int'(grant_idx));
         if (m_done == 2) req[2] = 1'b0;
         if (m_done == 0 && got.size() >= 3) req[0] = 1'b0;
      end
      tests_run++;
      if (got.size() != 3 || got[0] != 0 || got[1] != 2 || got[2] != 0) begin
         tests_failed++;
         $display("FAIL sticky_order got %p exp '{0, 2, 0}", got);
      end
   endtask

   task automatic test_random();
      int loads = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && $urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
               req_data[i*SIZE +: SIZE] = SIZE'($urandom);
               req_flag[i] = 1'($urandom);
            end else if (req[i] && $urandom_range(0, 7) == 0) begin
               req_data[i*SIZE +: SIZE] = SIZE'($urandom);
               req_flag[i] = 1'($urandom);
            end else if (req[i] && $urandom_range(0, 31) == 0) begin
               req[i] = 1'b0;   // dropped request
            end
         end
         step();
         tests_run++;
         if (dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL random_vec cyc=%0d got %b exp %b", cyc, dut_vec, model_vec());
         end
         if (m_phase == 2) begin
            tests_run++;
            if ({reg_data, reg_flag} !== {m_data, m_flag}) begin
               tests_failed++;
               $display("FAIL random_register cyc=%0d got %b exp %b", cyc,
                        {reg_data, reg_flag}, {m_data, m_flag});
            end
            loads++;
         end
         if (m_done >= 0 && $urandom_range(0, 3) != 0) req[m_done] = 1'b0;
      end
      tests_run++;
      if (loads < 20) begin
         tests_failed++;
         $display("FAIL random_activity got %0d loads exp at least 20", loads);
      end
   endtask

   initial begin
      model_reset();
      reg_data = '0;
      reg_flag = 1'b0;
      test_reset();
      test_single();
      test_wrap();
      test_round_robin();
      test_data_stable();
      test_reset_mid();
      test_sticky();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
